control_path_pipe_cpu: RTL and testbench

//  Pipelined successor of the single-cycle control path. Decodes the ID-stage instruction and carries

---
 rtl/control_path_pipe_cpu.sv | 192 +++++++++++++++++++
 tb/tb_control_path_pipe_cpu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_path_pipe_cpu.sv
// Pipelined control path: decodes the ID instruction, carries control through EX/MEM/WB,
// and generates load-use / MUL stalls, branch/jump flushes and the PC select.
module control_path_pipe_cpu #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  is_alu_zero,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            control_mux_for_PC,
    output logic                  illegal_op,
    output logic                  ex_is_R_type,
    output logic                  ex_is_I_type,
    output logic [5:0]            ex_opcode_alu,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  mem_is_write_mem,
    output logic                  wb_is_write_reg,
    output logic                  wb_is_write_from_mem,
    output logic [REG_ADDR_W-1:0] wb_dst
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_NOP  = 6'b111111;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_MUL = 6'b011000;

    localparam int                CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // An all-zero record is a bubble in every stage.
    typedef struct packed {
        logic                  is_r;
        logic                  is_i;
        logic [5:0]            alu_op;
        logic [REG_ADDR_W-1:0] dst;
        logic                  write_reg;
        logic                  from_mem;
        logic                  write_mem;
        logic                  is_beq;
    } ex_ctl_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  write_reg;
        logic                  from_mem;
        logic                  write_mem;
    } mem_ctl_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  write_reg;
        logic                  from_mem;
    } wb_ctl_t;

    ex_ctl_t          ex_q, ex_d, id_ctl;
    mem_ctl_t         mem_q, mem_d;
    wb_ctl_t          wb_q, wb_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic id_illegal, id_is_j, id_reads_rt;
    logic ex_is_mul, taken_beq, mul_hold, load_use, stall_raw, jump_take;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        id_ctl      = '0;
        id_illegal  = 1'b0;
        id_is_j     = 1'b0;
        id_reads_rt = 1'b0;
        if (instr_valid) begin
            case (opcode)
                OP_R: begin
                    id_reads_rt = 1'b1;
                    if (funct == ALU_ADD || funct == ALU_SUB || funct == ALU_MUL) begin
                        id_ctl.is_r   = 1'b1;
                        id_ctl.alu_op = funct;
                        id_ctl.dst    = rd;
                    end else begin
                        id_illegal = 1'b1;
                    end
                end
                OP_ADDI: begin
                    id_ctl.is_i   = 1'b1;
                    id_ctl.alu_op = ALU_ADD;
                    id_ctl.dst    = rt;
                end
                OP_LW: begin
                    id_ctl.is_i     = 1'b1;
                    id_ctl.alu_op   = ALU_ADD;
                    id_ctl.dst      = rt;
                    id_ctl.from_mem = 1'b1;
                end
                OP_SW: begin
                    id_reads_rt      = 1'b1;
                    id_ctl.is_i      = 1'b1;
                    id_ctl.alu_op    = ALU_ADD;
                    id_ctl.write_mem = 1'b1;
                end
                OP_BEQ: begin
                    // beq compares two registers: neither R-format nor immediate operand.
                    id_reads_rt   = 1'b1;
                    id_ctl.alu_op = ALU_SUB;
                    id_ctl.is_beq = 1'b1;
                end
                OP_J:    id_is_j = 1'b1;
                OP_NOP:  ;
                default: id_illegal = 1'b1;
            endcase
        end
        id_ctl.write_reg = (id_ctl.dst != '0);
    end

    assign ex_is_mul = (ex_q.alu_op == ALU_MUL);
    assign taken_beq = ex_q.is_beq && is_alu_zero;
    assign mul_hold  = ex_is_mul && (mul_cnt_q != CNT_LAST);
    assign load_use  = instr_valid && ex_q.from_mem && (ex_q.dst != '0) &&
                       ((ex_q.dst == rs) || (id_reads_rt && (ex_q.dst == rt)));
    assign stall_raw = !taken_beq && (load_use || mul_hold);
    assign jump_take = !taken_beq && !stall_raw && id_is_j;

    always_comb begin
        ex_d = id_ctl;
        if (taken_beq) begin
            ex_d = '0;
        end else if (mul_hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end

        mem_d = mul_hold ? '0 : {ex_q.dst, ex_q.write_reg, ex_q.from_mem, ex_q.write_mem};
        wb_d  = {mem_q.dst, mem_q.write_reg, mem_q.from_mem};

        mul_cnt_d = '0;
        if (ex_is_mul && mul_cnt_q != CNT_LAST) begin
            mul_cnt_d = mul_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            mul_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign stall              = rst && stall_raw;
    assign flush              = rst && (taken_beq || jump_take);
    assign control_mux_for_PC = !rst      ? PC_SEQ    :
                                taken_beq ? PC_BRANCH :
                                jump_take ? PC_JUMP   : PC_SEQ;
    assign illegal_op         = rst && id_illegal;

    assign ex_is_R_type         = ex_q.is_r;
    assign ex_is_I_type         = ex_q.is_i;
    assign ex_opcode_alu        = ex_q.alu_op;
    assign ex_dst               = ex_q.dst;
    assign mem_dst              = mem_q.dst;
    assign mem_is_write_mem     = mem_q.write_mem;
    assign wb_is_write_reg      = wb_q.write_reg;
    assign wb_is_write_from_mem = wb_q.from_mem;
    assign wb_dst               = wb_q.dst;

endmodule

// File: tb/tb_control_path_pipe_cpu.sv
// Self-checking bench: directed vector table, a mid-MUL reset sequence, and randomized
// stimulus compared against a cycle-level behavioural model of the pipeline.
module tb_control_path_pipe_cpu;

    localparam int AW  = 5;
    localparam int LAT = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_NOP  = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b010101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_MUL   = 6'b011000;
    localparam logic [5:0] F_BAD   = 6'b000111;
    localparam logic [5:0] F_NONE  = 6'b000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid;
    logic [5:0]    opcode, funct;
    logic [AW-1:0] rs, rt, rd;
    logic          is_alu_zero;
    logic          stall, flush, illegal_op;
    logic [1:0]    control_mux_for_PC;
    logic          ex_is_R_type, ex_is_I_type;
    logic [5:0]    ex_opcode_alu;
    logic [AW-1:0] ex_dst, mem_dst, wb_dst;
    logic          mem_is_write_mem, wb_is_write_reg, wb_is_write_from_mem;

    control_path_pipe_cpu #(.REG_ADDR_W(AW), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .is_alu_zero(is_alu_zero),
        .stall(stall), .flush(flush), .control_mux_for_PC(control_mux_for_PC),
        .illegal_op(illegal_op), .ex_is_R_type(ex_is_R_type), .ex_is_I_type(ex_is_I_type),
        .ex_opcode_alu(ex_opcode_alu), .ex_dst(ex_dst), .mem_dst(mem_dst),
        .mem_is_write_mem(mem_is_write_mem), .wb_is_write_reg(wb_is_write_reg),
        .wb_is_write_from_mem(wb_is_write_from_mem), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input int s, input int t, input int d, input logic z);
        instr_valid = v;
        opcode      = op;
        funct       = fn;
        rs          = AW'(s);
        rt          = AW'(t);
        rd          = AW'(d);
        is_alu_zero = z;
    endtask

    // Directed vectors: inputs for one cycle and what must be visible during that cycle.
    typedef struct {
        logic v; logic [5:0] op, fn; int s, t, d; logic z;
        logic st, fl; logic [1:0] pc; logic il;
        logic [5:0] ea; int ed, md; logic we; int wd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                input int s, input int t, input int d, input logic z,
                                input logic st, input logic fl, input logic [1:0] pc,
                                input logic il, input logic [5:0] ea, input int ed,
                                input int md, input logic we, input int wd);
        vec_t r;
        r.v = v; r.op = op; r.fn = fn; r.s = s; r.t = t; r.d = d; r.z = z;
        r.st = st; r.fl = fl; r.pc = pc; r.il = il;
        r.ea = ea; r.ed = ed; r.md = md; r.we = we; r.wd = wd;
        return r;
    endfunction

    // Behavioural model: each stage is a record of the control it carries; a MUL keeps
    // a count of the extra cycles it must still spend in EX.
    typedef struct packed {
        logic is_r, is_i; logic [5:0] alu; logic [AW-1:0] dst; logic wr, frm, wm, beq;
    } mctl_t;

    mctl_t m_ex, m_mem, m_wb;
    int    m_left;

    function automatic void mdecode(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                    input logic [AW-1:0] t, input logic [AW-1:0] d,
                                    output mctl_t c, output logic ill, output logic j,
                                    output logic rrt);
        c = '0; ill = 1'b0; j = 1'b0; rrt = 1'b0;
        if (v) begin
            rrt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
            case (op)
                OP_R:    if (fn == F_ADD || fn == F_SUB || fn == F_MUL) begin
                             c.is_r = 1'b1; c.alu = fn; c.dst = d;
                         end else ill = 1'b1;
                OP_ADDI: begin c.is_i = 1'b1; c.alu = F_ADD; c.dst = t; end
                OP_LW:   begin c.is_i = 1'b1; c.alu = F_ADD; c.dst = t; c.frm = 1'b1; end
                OP_SW:   begin c.is_i = 1'b1; c.alu = F_ADD; c.wm = 1'b1; end
                OP_BEQ:  begin c.alu = F_SUB; c.beq = 1'b1; end
                OP_J:    j = 1'b1;
                OP_NOP:  ;
                default: ill = 1'b1;
            endcase
            c.wr = (c.dst != 0);
        end
    endfunction

    vec_t  vecs[26];
    logic [5:0] op_pool[10];
    logic [5:0] fn_pool[7];

    initial begin
        vecs[0]  = mk(1, OP_R,    F_ADD,  1, 2, 3, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 0, 0);
        vecs[1]  = mk(1, OP_SW,   F_NONE, 4, 3, 0, 0,  0, 0, 0, 0,  F_ADD,  3, 0, 0, 0);
        vecs[2]  = mk(1, OP_NOP,  F_NONE, 0, 0, 0, 0,  0, 0, 0, 0,  F_ADD,  0, 3, 0, 0);
        vecs[3]  = mk(1, OP_LW,   F_NONE, 1, 5, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 1, 3);
        vecs[4]  = mk(1, OP_R,    F_ADD,  5, 1, 6, 0,  1, 0, 0, 0,  F_ADD,  5, 0, 0, 0);
        vecs[5]  = mk(1, OP_R,    F_ADD,  5, 1, 6, 0,  0, 0, 0, 0,  F_NONE, 0, 5, 0, 0);
        vecs[6]  = mk(1, OP_R,    F_MUL,  1, 2, 4, 0,  0, 0, 0, 0,  F_ADD,  6, 0, 1, 5);
        vecs[7]  = mk(1, OP_J,    F_NONE, 0, 0, 0, 0,  1, 0, 0, 0,  F_MUL,  4, 6, 0, 0);
        vecs[8]  = mk(1, OP_J,    F_NONE, 0, 0, 0, 0,  1, 0, 0, 0,  F_MUL,  4, 0, 1, 6);
        vecs[9]  = mk(1, OP_J,    F_NONE, 0, 0, 0, 0,  1, 0, 0, 0,  F_MUL,  4, 0, 0, 0);
        vecs[10] = mk(1, OP_J,    F_NONE, 0, 0, 0, 0,  0, 1, 2, 0,  F_MUL,  4, 0, 0, 0);
        vecs[11] = mk(1, OP_BEQ,  F_NONE, 1, 2, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 4, 0, 0);
        vecs[12] = mk(1, OP_J,    F_NONE, 0, 0, 0, 1,  0, 1, 1, 0,  F_SUB,  0, 0, 1, 4);
        vecs[13] = mk(1, OP_ADDI, F_NONE, 1, 0, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 0, 0);
        vecs[14] = mk(1, OP_BAD,  F_NONE, 1, 2, 3, 0,  0, 0, 0, 1,  F_ADD,  0, 0, 0, 0);
        vecs[15] = mk(1, OP_NOP,  F_NONE, 0, 0, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 0, 0);
        vecs[16] = mk(1, OP_R,    F_BAD,  1, 2, 3, 0,  0, 0, 0, 1,  F_NONE, 0, 0, 0, 0);
        vecs[17] = mk(0, OP_J,    F_NONE, 0, 0, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 0, 0);
        vecs[18] = mk(1, OP_LW,   F_NONE, 1, 7, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 0, 0, 0);
        vecs[19] = mk(0, OP_R,    F_ADD,  7, 7, 2, 0,  0, 0, 0, 0,  F_ADD,  7, 0, 0, 0);
        vecs[20] = mk(1, OP_LW,   F_NONE, 1, 8, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 7, 0, 0);
        vecs[21] = mk(1, OP_SW,   F_NONE, 1, 8, 0, 0,  1, 0, 0, 0,  F_ADD,  8, 0, 1, 7);
        vecs[22] = mk(1, OP_SW,   F_NONE, 1, 8, 0, 0,  0, 0, 0, 0,  F_NONE, 0, 8, 0, 0);
        vecs[23] = mk(1, OP_LW,   F_NONE, 2, 9, 0, 0,  0, 0, 0, 0,  F_ADD,  0, 0, 1, 8);
        vecs[24] = mk(1, OP_ADDI, F_NONE, 1, 9, 0, 0,  0, 0, 0, 0,  F_ADD,  9, 0, 0, 0);
        vecs[25] = mk(1, OP_BEQ,  F_NONE, 9, 1, 0, 1,  0, 0, 0, 0,  F_ADD,  9, 9, 0, 0);

        op_pool = '{OP_R, OP_R, OP_R, OP_ADDI, OP_LW, OP_LW, OP_SW, OP_BEQ, OP_J, OP_NOP};
        fn_pool = '{F_ADD, F_ADD, F_SUB, F_MUL, F_MUL, F_MUL, F_BAD};

        // Reset with a j sitting in ID: every output must stay quiet.
        drive(1'b1, OP_J, F_NONE, 0, 0, 0, 1'b0);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_flush", flush, 0);
        check("rst_pcsel", control_mux_for_PC, 0);
        check("rst_ex_alu", ex_opcode_alu, 0);
        check("rst_mem_dst", mem_dst, 0);
        check("rst_wb_we", wb_is_write_reg, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].z);
            #1;
            check($sformatf("v%0d_stall", i),   stall,              vecs[i].st);
            check($sformatf("v%0d_flush", i),   flush,              vecs[i].fl);
            check($sformatf("v%0d_pcsel", i),   control_mux_for_PC, vecs[i].pc);
            check($sformatf("v%0d_illegal", i), illegal_op,         vecs[i].il);
            check($sformatf("v%0d_ex_alu", i),  ex_opcode_alu,      vecs[i].ea);
            check($sformatf("v%0d_ex_dst", i),  ex_dst,             vecs[i].ed);
            check($sformatf("v%0d_mem_dst", i), mem_dst,            vecs[i].md);
            check($sformatf("v%0d_wb_we", i),   wb_is_write_reg,    vecs[i].we);
            check($sformatf("v%0d_wb_dst", i),  wb_dst,             vecs[i].wd);
            @(negedge clk);
        end

        // Reset asserted in the middle of a MUL stall, then a clean restart.
        drive(1'b1, OP_NOP, F_NONE, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b1, OP_R, F_MUL, 1, 2, 4, 1'b0);
        @(negedge clk);
        #1;
        check("mulrst_pre_stall", stall, 1);
        check("mulrst_pre_ex_alu", ex_opcode_alu, F_MUL);
        #2 rst = 1'b0;
        #1;
        check("mulrst_stall", stall, 0);
        check("mulrst_ex_alu", ex_opcode_alu, 0);
        check("mulrst_ex_dst", ex_dst, 0);
        check("mulrst_ex_r", ex_is_R_type, 0);
        check("mulrst_mem_dst", mem_dst, 0);
        check("mulrst_wb_we", wb_is_write_reg, 0);
        check("mulrst_wb_dst", wb_dst, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, OP_R, F_ADD, 1, 2, 3, 1'b0);
        @(negedge clk);
        drive(1'b1, OP_NOP, F_NONE, 0, 0, 0, 1'b0);
        #1;
        check("restart_ex_alu", ex_opcode_alu, F_ADD);
        check("restart_ex_dst", ex_dst, 3);
        check("restart_stall", stall, 0);
        check("restart_mem_dst", mem_dst, 0);

        // Randomized run against the model.
        @(negedge clk);
        rst = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_left = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            logic v, z, ill, j, rrt, taken, mh, lu, e_stall;
            logic [1:0] e_pc;
            logic [5:0] op, fn;
            mctl_t dec;
            v  = ($urandom_range(0, 9) != 0);
            z  = $urandom_range(0, 1);
            op = ($urandom_range(0, 19) == 0) ? OP_BAD : op_pool[$urandom_range(0, 9)];
            fn = fn_pool[$urandom_range(0, 6)];
            drive(v, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), z);
            #1;
            mdecode(v, op, fn, rt, rd, dec, ill, j, rrt);
            taken   = m_ex.beq && z;
            mh      = (m_ex.alu == F_MUL) && (m_left > 0);
            lu      = v && m_ex.frm && (m_ex.dst != 0) &&
                      ((m_ex.dst == rs) || (rrt && (m_ex.dst == rt)));
            e_stall = !taken && (lu || mh);
            e_pc    = taken ? 2'b01 : (!e_stall && j) ? 2'b10 : 2'b00;

            check("rnd_stall",   stall,                e_stall);
            check("rnd_flush",   flush,                e_pc != 2'b00);
            check("rnd_pcsel",   control_mux_for_PC,   e_pc);
            check("rnd_illegal", illegal_op,           ill);
            check("rnd_ex_r",    ex_is_R_type,         m_ex.is_r);
            check("rnd_ex_i",    ex_is_I_type,         m_ex.is_i);
            check("rnd_ex_alu",  ex_opcode_alu,        m_ex.alu);
            check("rnd_ex_dst",  ex_dst,               m_ex.dst);
            check("rnd_mem_dst", mem_dst,              m_mem.dst);
            check("rnd_mem_wm",  mem_is_write_mem,     m_mem.wm);
            check("rnd_wb_we",   wb_is_write_reg,      m_wb.wr);
            check("rnd_wb_frm",  wb_is_write_from_mem, m_wb.frm);
            check("rnd_wb_dst",  wb_dst,               m_wb.dst);

            m_wb  = m_mem;
            m_mem = mh ? mctl_t'('0) : m_ex;
            if (taken || (!mh && lu)) begin
                m_ex   = '0;
                m_left = 0;
            end else if (mh) begin
                m_left--;
            end else begin
                m_ex   = dec;
                m_left = (dec.alu == F_MUL) ? LAT - 1 : 0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
